// File: rtl/matrix_engine_pkg.sv
// Shared encodings for the Wishbone matrix engine: address regions, control
// register indices, operation codes and sequencer states.
package matrix_engine_pkg;

  typedef enum logic [1:0] {
    REGION_CTRL = 2'b00,
    REGION_A    = 2'b01,
    REGION_B    = 2'b10,
    REGION_C    = 2'b11
  } region_e;

  typedef enum logic [2:0] {
    IDX_OP     = 3'd0,
    IDX_M      = 3'd1,
    IDX_K      = 3'd2,
    IDX_P      = 3'd3,
    IDX_CTRL   = 3'd4,
    IDX_STATUS = 3'd5,
    IDX_IRQEN  = 3'd6,
    IDX_RSVD   = 3'd7
  } ctrl_idx_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_MUL = 2'd1,
    OP_ADD = 2'd2,
    OP_HAD = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/matrix_engine_mac.sv
// Single arithmetic lane: multiply or add two operands and accumulate,
// with a clear that restarts the accumulation from zero.
module matrix_engine_mac
  import matrix_engine_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          en,
  input  logic          clr,
  input  logic          add_mode,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] acc
);

  logic [DW-1:0] acc_reg;
  logic [DW-1:0] term;
  logic [DW-1:0] base;

  always_comb begin
    term = add_mode ? (a + b) : (a * b);
    base = clr ? '0 : acc_reg;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= base + term;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/matrix_engine_wb.sv
// Wishbone-mapped matrix engine: A/B/C operand stores, control registers and a
// sequencer that walks C row-major through one shared multiply/add lane.
module matrix_engine_wb
  import matrix_engine_pkg::*;
#(
  parameter int DW = 32,
  parameter int N  = 4
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic [31:0]   wb_addr_i,
  input  logic          wb_we_i,
  input  logic          wb_stb_i,
  input  logic [DW-1:0] wb_data_i,
  output logic          wb_ack_o,
  output logic [DW-1:0] wb_data_o,
  output logic          irq_o
);

  localparam int IW = $clog2(N);

  state_e        state_reg, state_next;
  logic [DW-1:0] cfg_op_reg, cfg_m_reg, cfg_k_reg, cfg_p_reg;
  logic          irqen_reg, done_reg, done_next, err_reg, err_next;
  logic          ack_reg, irq_reg;
  logic [DW-1:0] data_reg, rd_next;
  logic [IW-1:0] i_reg, j_reg, k_reg;

  logic [DW-1:0] a_mem [N][N];
  logic [DW-1:0] b_mem [N][N];
  logic [DW-1:0] c_mem [N][N];

  region_e       region;
  ctrl_idx_e     reg_idx;
  logic [29-IW:0] row_full;
  logic [IW-1:0] row_idx, col_idx;
  logic          in_range, busy;
  logic          acc_stb, wr, ctrl_wr, cfg_wr, status_wr, a_we, b_we, drop_err;
  logic          start, start_ok, start_bad, op_valid, dims_ok;
  op_e           op_sel;
  logic          elem_mode, last_k, last_elem;
  logic [IW-1:0] m_lim, k_lim, p_lim;
  logic          mac_en, mac_clr, mac_add, c_we;
  logic [DW-1:0] mac_a, mac_b, mac_acc;

  function automatic logic dim_ok(input logic [DW-1:0] v);
    return (v != '0) && (v <= DW'(N));
  endfunction

  // Everything above the column field belongs to the row, so rows past N
  // are caught instead of aliasing onto a valid row.
  assign region   = region_e'(wb_addr_i[31:30]);
  assign reg_idx  = ctrl_idx_e'(wb_addr_i[2:0]);
  assign row_full = wb_addr_i[29:IW];
  assign row_idx  = row_full[IW-1:0];
  assign col_idx  = wb_addr_i[IW-1:0];
  assign in_range = (32'(row_full) < N) && (32'(col_idx) < N);
  assign busy     = (state_reg != ST_IDLE);

  assign acc_stb   = wb_stb_i & ~ack_reg;
  assign wr        = acc_stb & wb_we_i;
  assign ctrl_wr   = wr && (region == REGION_CTRL);
  assign cfg_wr    = ctrl_wr && !busy;
  assign status_wr = ctrl_wr && (reg_idx == IDX_STATUS);
  assign a_we      = wr && (region == REGION_A) && in_range && !busy;
  assign b_we      = wr && (region == REGION_B) && in_range && !busy;
  assign drop_err  = busy && wr &&
                     ((region == REGION_A) || (region == REGION_B) ||
                      ((region == REGION_CTRL) && (reg_idx <= IDX_P)));

  assign op_sel    = op_e'(cfg_op_reg[1:0]);
  assign op_valid  = (cfg_op_reg[DW-1:2] == '0) && (op_sel != OP_NOP);
  assign dims_ok   = dim_ok(cfg_m_reg) && dim_ok(cfg_k_reg) && dim_ok(cfg_p_reg);
  assign start     = ctrl_wr && (reg_idx == IDX_CTRL) && wb_data_i[0] && !busy;
  assign start_ok  = start && op_valid && dims_ok;
  assign start_bad = start && !(op_valid && dims_ok);

  // Dimensions are validated to 1..N, so the IW-bit wrap of dim-1 is exact.
  assign m_lim     = IW'(cfg_m_reg - DW'(1));
  assign k_lim     = IW'(cfg_k_reg - DW'(1));
  assign p_lim     = IW'(cfg_p_reg - DW'(1));
  assign elem_mode = (op_sel != OP_MUL);
  assign last_k    = (k_reg == k_lim);
  assign last_elem = (i_reg == m_lim) && (j_reg == p_lim);

  always_comb begin
    state_next = state_reg;
    mac_en     = 1'b0;
    mac_clr    = elem_mode || (k_reg == '0);
    mac_add    = (op_sel == OP_ADD);
    c_we       = 1'b0;
    mac_a      = elem_mode ? a_mem[i_reg][j_reg] : a_mem[i_reg][k_reg];
    mac_b      = elem_mode ? b_mem[i_reg][j_reg] : b_mem[k_reg][j_reg];
    unique case (state_reg)
      ST_IDLE:  if (start_ok) state_next = ST_CALC;
      ST_CALC: begin
        mac_en = 1'b1;
        if (elem_mode || last_k) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        c_we       = 1'b1;
        state_next = last_elem ? ST_DONE : ST_CALC;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // A done raised this cycle wins over a simultaneous W1C of the same bit.
  always_comb begin
    done_next = done_reg;
    err_next  = err_reg;
    if (status_wr && wb_data_i[1]) done_next = 1'b0;
    if (status_wr && wb_data_i[2]) err_next  = 1'b0;
    if (start) begin
      done_next = 1'b0;
      err_next  = 1'b0;
    end
    if (start_bad || (state_reg == ST_DONE)) done_next = 1'b1;
    if (start_bad || drop_err) err_next = 1'b1;
  end

  always_comb begin
    rd_next = '0;
    unique case (region)
      REGION_CTRL: begin
        unique case (reg_idx)
          IDX_OP:     rd_next = cfg_op_reg;
          IDX_M:      rd_next = cfg_m_reg;
          IDX_K:      rd_next = cfg_k_reg;
          IDX_P:      rd_next = cfg_p_reg;
          IDX_STATUS: rd_next = DW'({err_reg, done_reg, busy});
          IDX_IRQEN:  rd_next = DW'(irqen_reg);
          default:    rd_next = '0;
        endcase
      end
      REGION_A: if (in_range) rd_next = a_mem[row_idx][col_idx];
      REGION_B: if (in_range) rd_next = b_mem[row_idx][col_idx];
      REGION_C: if (in_range && !busy) rd_next = c_mem[row_idx][col_idx];
      default:  rd_next = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg  <= ST_IDLE;
      cfg_op_reg <= '0;
      cfg_m_reg  <= '0;
      cfg_k_reg  <= '0;
      cfg_p_reg  <= '0;
      irqen_reg  <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      ack_reg    <= 1'b0;
      data_reg   <= '0;
      irq_reg    <= 1'b0;
      i_reg      <= '0;
      j_reg      <= '0;
      k_reg      <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      ack_reg   <= acc_stb;
      irq_reg   <= done_reg & irqen_reg;
      if (acc_stb) data_reg <= wb_we_i ? '0 : rd_next;
      if (cfg_wr && (reg_idx == IDX_OP)) cfg_op_reg <= wb_data_i;
      if (cfg_wr && (reg_idx == IDX_M))  cfg_m_reg  <= wb_data_i;
      if (cfg_wr && (reg_idx == IDX_K))  cfg_k_reg  <= wb_data_i;
      if (cfg_wr && (reg_idx == IDX_P))  cfg_p_reg  <= wb_data_i;
      if (ctrl_wr && (reg_idx == IDX_IRQEN)) irqen_reg <= wb_data_i[0];
      unique case (state_reg)
        ST_IDLE: begin
          i_reg <= '0;
          j_reg <= '0;
          k_reg <= '0;
        end
        ST_CALC: k_reg <= k_reg + IW'(1);
        ST_WRITE: begin
          k_reg <= '0;
          if (j_reg == p_lim) begin
            j_reg <= '0;
            i_reg <= i_reg + IW'(1);
          end else begin
            j_reg <= j_reg + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_mem[r][c] <= '0;
          b_mem[r][c] <= '0;
          c_mem[r][c] <= '0;
        end
      end
    end else begin
      if (a_we) a_mem[row_idx][col_idx] <= wb_data_i;
      if (b_we) b_mem[row_idx][col_idx] <= wb_data_i;
      if (c_we) c_mem[i_reg][j_reg] <= mac_acc;
    end
  end

  matrix_engine_mac #(.DW(DW)) u_mac (
    .wb_clk_i (wb_clk_i),
    .wb_rst_ni(wb_rst_ni),
    .en       (mac_en),
    .clr      (mac_clr),
    .add_mode (mac_add),
    .a        (mac_a),
    .b        (mac_b),
    .acc      (mac_acc)
  );

  assign wb_ack_o  = ack_reg;
  assign wb_data_o = data_reg;
  assign irq_o     = irq_reg;

endmodule

// File: tb/tb_matrix_engine_wb.sv
// Self-checking bench for matrix_engine_wb: register table, directed corner
// sequences and randomized runs against a plain matrix-arithmetic model.
module tb_matrix_engine_wb;

  localparam int DW = 32;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   addr = '0;
  logic          we = 1'b0;
  logic          stb = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          ack;
  logic [DW-1:0] rdata;
  logic          irq;

  int errors = 0;
  int checks = 0;

  int unsigned a_m [N][N];
  int unsigned b_m [N][N];
  int unsigned c_m [N][N];

  always #5 clk = ~clk;

  matrix_engine_wb #(.DW(DW), .N(N)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wb_addr_i(addr),
    .wb_we_i  (we),
    .wb_stb_i (stb),
    .wb_data_i(wdata),
    .wb_ack_o (ack),
    .wb_data_o(rdata),
    .irq_o    (irq)
  );

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  function automatic logic [31:0] ea(int region, int row, int col);
    return (32'(region) << 30) | (32'(row) << 2) | 32'(col);
  endfunction

  function automatic logic [31:0] ca(int idx);
    return 32'(idx);
  endfunction

  function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] d, logic [31:0] e, string n);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%08h", name, act);
    end
  endtask

  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] r);
    int n;
    @(negedge clk);
    we = w; addr = a; wdata = d; stb = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ack !== 1'b1 && n < 8);
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL ack_timeout: addr 0x%08h got no ack, expected ack within 8 cycles", a);
    end
    r = rdata;
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    xfer(1'b1, a, d, dummy);
  endtask

  task automatic rd_check(string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    xfer(1'b0, a, '0, r);
    check(name, r, exp);
  endtask

  task automatic set_a(int r, int c, int unsigned v);
    wr(ea(1, r, c), v);
    a_m[r][c] = v;
  endtask

  task automatic set_b(int r, int c, int unsigned v);
    wr(ea(2, r, c), v);
    b_m[r][c] = v;
  endtask

  task automatic cfg(int op, int m, int k, int p);
    wr(ca(0), 32'(op)); wr(ca(1), 32'(m)); wr(ca(2), 32'(k)); wr(ca(3), 32'(p));
  endtask

  task automatic clear_status();
    wr(ca(5), 32'h6);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Reference: matrix arithmetic on the shadow arrays plus the cycle formulas.
  task automatic model_run(input int op, input int m, input int k, input int p,
                           output int exp_cycles, output logic [31:0] exp_status);
    bit valid;
    valid = (op >= 1 && op <= 3) && (m >= 1 && m <= N) && (k >= 1 && k <= N) && (p >= 1 && p <= N);
    if (!valid) begin
      exp_cycles = 0;
      exp_status = 32'h6;
      return;
    end
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < p; j++) begin
        int unsigned s;
        if (op == 1) begin
          s = 0;
          for (int kk = 0; kk < k; kk++) s += a_m[i][kk] * b_m[kk][j];
        end else if (op == 2) begin
          s = a_m[i][j] + b_m[i][j];
        end else begin
          s = a_m[i][j] * b_m[i][j];
        end
        c_m[i][j] = s;
      end
    end
    exp_cycles = (op == 1) ? (m * p * (k + 1) + 1) : (2 * m * p + 1);
    exp_status = 32'h2;
  endtask

  // Busy length is inferred from irq: it rises one cycle after busy falls.
  task automatic start_and_measure(output int busy_cycles);
    int n;
    wr(ca(4), 32'h1);
    n = 0;
    while (irq !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    busy_cycles = n - 1;
  endtask

  task automatic check_all_c(string tag);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        rd_check($sformatf("%s C[%0d][%0d]", tag, r, c), ea(3, r, c), c_m[r][c]);
  endtask

  task automatic run_case(string tag, int op, int m, int k, int p);
    int exp_cyc, cyc;
    logic [31:0] exp_st;
    clear_status();
    cfg(op, m, k, p);
    model_run(op, m, k, p, exp_cyc, exp_st);
    start_and_measure(cyc);
    $display("run  %s op=%0d M=%0d K=%0d P=%0d busy=%0d", tag, op, m, k, p, cyc);
    check({tag, " busy_cycles"}, 32'(cyc), 32'(exp_cyc));
    rd_check({tag, " status"}, ca(5), exp_st);
    check({tag, " irq"}, 32'(irq), 32'h1);
    check_all_c(tag);
  endtask

  vec_t tbl[$];

  initial begin
    int exp_cyc, cyc;
    logic [31:0] exp_st;

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a_m[r][c] = 0; b_m[r][c] = 0; c_m[r][c] = 0;
      end

    repeat (3) @(posedge clk);
    #1;
    check("rst ack", 32'(ack), 32'h0);
    check("rst irq", 32'(irq), 32'h0);
    check("rst rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Register map, reset values and out-of-range element access.
    tbl.push_back(mk(0, ca(0), 0, 32'h0, "rst OP"));
    tbl.push_back(mk(0, ca(1), 0, 32'h0, "rst M"));
    tbl.push_back(mk(0, ca(2), 0, 32'h0, "rst K"));
    tbl.push_back(mk(0, ca(3), 0, 32'h0, "rst P"));
    tbl.push_back(mk(0, ca(5), 0, 32'h0, "rst STATUS"));
    tbl.push_back(mk(0, ca(6), 0, 32'h0, "rst IRQEN"));
    tbl.push_back(mk(0, ea(1, 0, 0), 0, 32'h0, "rst A[0][0]"));
    tbl.push_back(mk(0, ea(3, 3, 3), 0, 32'h0, "rst C[3][3]"));
    tbl.push_back(mk(1, ca(0), 32'h3, 0, "wr OP"));
    tbl.push_back(mk(0, ca(0), 0, 32'h3, "rd OP"));
    tbl.push_back(mk(1, ca(1), 32'hAB, 0, "wr M"));
    tbl.push_back(mk(0, ca(1), 0, 32'hAB, "rd M"));
    tbl.push_back(mk(1, ca(6), 32'hFFFF_FFFF, 0, "wr IRQEN"));
    tbl.push_back(mk(0, ca(6), 0, 32'h1, "rd IRQEN"));
    tbl.push_back(mk(1, ca(7), 32'h55, 0, "wr idx7"));
    tbl.push_back(mk(0, ca(7), 0, 32'h0, "rd idx7"));
    tbl.push_back(mk(0, ca(4), 0, 32'h0, "rd CTRL"));
    tbl.push_back(mk(1, ea(1, 1, 2), 32'hDEAD_BEEF, 0, "wr A[1][2]"));
    tbl.push_back(mk(0, ea(1, 1, 2), 0, 32'hDEAD_BEEF, "rd A[1][2]"));
    tbl.push_back(mk(1, ea(2, 3, 0), 32'h7, 0, "wr B[3][0]"));
    tbl.push_back(mk(0, ea(2, 3, 0), 0, 32'h7, "rd B[3][0]"));
    tbl.push_back(mk(1, ea(1, 5, 1), 32'h1234, 0, "wr A[5][1]"));
    tbl.push_back(mk(0, ea(1, 5, 1), 0, 32'h0, "rd A[5][1]"));
    tbl.push_back(mk(0, ea(1, 1, 1), 0, 32'h0, "rd A[1][1] no alias"));
    tbl.push_back(mk(0, ea(3, 5, 0), 0, 32'h0, "rd C[5][0]"));
    foreach (tbl[t]) begin
      if (tbl[t].w) wr(tbl[t].a, tbl[t].d);
      else rd_check(tbl[t].name, tbl[t].a, tbl[t].exp);
    end
    a_m[1][2] = 32'hDEAD_BEEF;
    b_m[3][0] = 32'h7;

    // Held strobe: ack must alternate, never two in a row.
    repeat (2) @(negedge clk);
    addr = ca(5); we = 1'b0; stb = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      check($sformatf("ack pattern %0d", n), 32'(ack), (n % 2 == 0) ? 32'h1 : 32'h0);
    end
    stb = 1'b0;

    // 2x2 multiply from the worked example.
    set_a(0, 0, 1); set_a(0, 1, 2); set_a(1, 0, 3); set_a(1, 1, 4);
    set_b(0, 0, 5); set_b(0, 1, 6); set_b(1, 0, 7); set_b(1, 1, 8);
    run_case("mul2x2", 1, 2, 2, 2);

    // W1C clears done and error; irq follows one cycle later.
    wr(ca(5), 32'h6);
    @(posedge clk); #1;
    check("w1c irq", 32'(irq), 32'h0);
    rd_check("w1c status", ca(5), 32'h0);

    // 3x3 add with wraparound.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        set_a(r, c, 32'(r + c));
        set_b(r, c, 32'hFFFF_FFFF);
      end
    run_case("add3x3", 2, 3, 3, 3);

    // Illegal K: immediate done+error, nothing computed.
    run_case("badK", 1, 2, 5, 2);

    // Bus traffic while busy.
    clear_status();
    cfg(1, 4, 4, 4);
    model_run(1, 4, 4, 4, exp_cyc, exp_st);
    wr(ca(4), 32'h1);
    wr(ea(1, 0, 0), 32'h9);
    rd_check("busy C[0][0]", ea(3, 0, 0), 32'h0);
    rd_check("busy status", ca(5), 32'h5);
    cyc = 0;
    while (irq !== 1'b1 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("busy irq", 32'(irq), 32'h1);
    rd_check("busy end status", ca(5), 32'h6);
    rd_check("busy A[0][0]", ea(1, 0, 0), a_m[0][0]);
    check_all_c("mul4x4");

    // Reset in the middle of a multiply.
    clear_status();
    wr(ca(4), 32'h1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst irq", 32'(irq), 32'h0);
    check("midrst ack", 32'(ack), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a_m[r][c] = 0; b_m[r][c] = 0; c_m[r][c] = 0;
      end
    rd_check("midrst status", ca(5), 32'h0);
    rd_check("midrst C[0][0]", ea(3, 0, 0), 32'h0);
    rd_check("midrst IRQEN", ca(6), 32'h0);
    wr(ca(6), 32'h1);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) set_a(r, c, 32'(r * 3 + c + 1));
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 2; c++) set_b(r, c, 32'(10 + r - c));
    run_case("fresh", 1, 2, 3, 2);

    // Randomized runs, occasionally with an illegal op or dimension.
    for (int it = 0; it < 8; it++) begin
      int op, m, k, p;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          set_a(r, c, $urandom);
          set_b(r, c, $urandom);
        end
      op = $urandom_range(1, 3);
      m = $urandom_range(1, N);
      k = $urandom_range(1, N);
      p = $urandom_range(1, N);
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: op = ($urandom_range(0, 1) == 0) ? 0 : 5;
          1: m = 0;
          2: k = N + 1;
          default: p = 0;
        endcase
      end
      run_case($sformatf("rand%0d", it), op, m, k, p);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_engine_wb.md
MATRIX_ENGINE_WB -- requirements
Module: matrix_engine_wb

Interface
REQ-001 SHALL have parameter DW, default 32, element/data width in bits (also Wishbone data width).
REQ-002 SHALL have parameter N, default 4, maximum matrix dimension; IW = clog2(N) index bits.
REQ-003 SHALL have ports: wb_clk_i  in  1  sole clock.
REQ-004 SHALL have ports: wb_rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports: wb_addr_i  in  32  word address; [31:30] region (00 ctrl, 01 A, 10 B, 11 C), [2*IW-1:IW] row, [IW-1:0] column, [2:0] ctrl register index.
REQ-006 SHALL have ports: wb_we_i  in  1  write enable; wb_stb_i  in  1  strobe; wb_data_i  in  DW  write data.
REQ-007 SHALL have ports: wb_ack_o  out  1  transfer acknowledge; wb_data_o  out  DW  read data; irq_o  out  1  completion interrupt.

Function
REQ-008 SHALL provide ctrl registers: 0 OP (1 multiply, 2 add, 3 Hadamard, others nop), 1 M, 2 K, 3 P, 4 CTRL (write bit0=1 starts), 5 STATUS (bit0 busy, bit1 done W1C, bit2 error W1C), 6 IRQEN (bit0); indices 7 read 0.
REQ-009 SHALL ack every strobe: wb_ack_o high exactly one cycle, the cycle after wb_stb_i sampled high with wb_ack_o low; no back-to-back acks.
REQ-010 SHALL return read data in the ack cycle; out-of-range index (row or column >= N) reads 0 and writes are dropped.
REQ-011 SHALL, while busy: ack all accesses; accept STATUS/IRQEN writes and all ctrl reads; drop writes to OP, M, K, P, A, B and set error; read C as 0.
REQ-012 SHALL, on start with OP=nop or any of M, K, P equal 0 or > N, set done and error without computing, busy never asserted.
REQ-013 SHALL ignore start while busy; start clears done and error.
REQ-014 SHALL implement FSM IDLE -> CALC -> WRITE -> (CALC | DONE) -> IDLE; busy high in CALC, WRITE, DONE.
REQ-015 SHALL, multiply: per (i,j) row-major, K CALC cycles accumulating A[i][k]*B[k][j], k=0..K-1, then one WRITE to C[i][j]; busy lasts M*P*(K+1)+1 cycles.
REQ-016 SHALL, add/Hadamard: C[i][j] = A[i][j]+B[i][j] or A[i][j]*B[i][j], i<M, j<P, one CALC plus one WRITE per element; busy lasts 2*M*P+1 cycles.
REQ-017 SHALL use unsigned DW-bit arithmetic, products and sums truncated modulo 2^DW.
REQ-018 SHALL leave C elements outside the computed region unchanged.
REQ-019 SHALL set done in the DONE cycle; irq_o = done & IRQEN[0], registered.
REQ-020 SHALL give a same-cycle STATUS W1C write priority below a done set in that cycle.

Reset
REQ-021 SHALL, on wb_rst_ni low, asynchronously clear FSM to IDLE, all ctrl registers, A, B, C, wb_ack_o, wb_data_o, irq_o to 0, including mid-operation; no result retained.

Structure
REQ-022 SHALL place region codes, ctrl register indices, OP encodings and FSM state typedef in shared package matrix_engine_pkg.
REQ-023 SHALL instantiate one sub-module matrix_engine_mac (DW-bit multiply/add with accumulate and clear); no other hierarchy.

Verification
REQ-024 Multiply N=4: M=K=P=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start -> busy 13 cycles, C=[[19,22],[43,50]], done=1, irq_o=1 with IRQEN=1.
REQ-025 Add 3x3, A[i][j]=i+j, B all 0xFFFFFFFF -> C[i][j]=i+j-1 mod 2^32 (C[0][0]=0xFFFFFFFF), busy 19 cycles.
REQ-026 Start with K=5 (N=4) -> done=1, error=1, busy never 1, C unchanged.
REQ-027 Write A[0][0]=9 and read C while busy -> both acked, A unchanged, C read 0, error=1 at completion.
REQ-028 Assert wb_rst_ni mid-multiply -> next cycle busy=0, C reads 0, irq_o=0; fresh run completes correctly.
REQ-029 Access row 5 (N=4) -> ack, read 0, write dropped; STATUS W1C 0x6 clears done and error, irq_o drops next cycle.
